// File: rtl/br_pred_update_ctrl.sv
// -----------------------------------------------------------------------------
// br_pred_update_ctrl
//
// Purpose
//   Glue between fetch/execute and a 2-bit-counter pattern history table.
//   It does three jobs:
//     * Forms the gshare read index from the fetch PC and the speculative
//       global history register (GHR). The GHR shifts in each fetched
//       conditional branch's prediction.
//     * Queues resolved-branch outcomes in a small FIFO. A three-state
//       drain FSM retires them as one registered PHT write strobe per cycle.
//     * Repairs the GHR from the branch's own history snapshot on a
//       misprediction, and pulses mis_predict one cycle later.
//
// Parameters
//   PHTIDX  PHT index width (2**PHTIDX entries)
//   GHRLEN  GHR width, 2 <= GHRLEN <= PHTIDX (zero-extended before the XOR)
//   QDEPTH  update FIFO depth, power of two, >= 2
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   fetch_valid/pc/opcode   fetch slot; opcode 7'b1100011 is a conditional branch
//   pht_r_idx       combinational PHT read index
//   pred_result     PHT prediction for pht_r_idx
//   pred_taken      pred_result qualified by a valid branch fetch
//   fetch_ghr       GHR before this fetch's shift (carried down the pipe)
//   resolve_*       resolved-branch offer; resolve_ready = FIFO not full
//   upd_stall       PHT write port busy, hold the drain
//   pht_w_idx, br_en, update_pht   registered PHT write request
//   mis_predict     one-cycle pulse after a mispredicted resolve handshake
//
// Configuration
//   BP_STATS_EN  when defined, adds br_cnt (resolve handshakes) and
//                mispred_cnt (mispredicts) 32-bit wrapping counters.
// -----------------------------------------------------------------------------
module br_pred_update_ctrl #(
    parameter int PHTIDX = 4,
    parameter int GHRLEN = 4,
    parameter int QDEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              fetch_valid,
    input  logic [31:0]       fetch_pc,
    input  logic [6:0]        fetch_opcode,
    output logic [PHTIDX-1:0] pht_r_idx,
    input  logic              pred_result,
    output logic              pred_taken,
    output logic [GHRLEN-1:0] fetch_ghr,

    input  logic              resolve_valid,
    output logic              resolve_ready,
    input  logic [31:0]       resolve_pc,
    input  logic              resolve_taken,
    input  logic              resolve_pred,
    input  logic [GHRLEN-1:0] resolve_ghr,

    input  logic              upd_stall,
    output logic [PHTIDX-1:0] pht_w_idx,
    output logic              br_en,
    output logic              update_pht,
    output logic              mis_predict
`ifdef BP_STATS_EN
    ,
    output logic [31:0]       br_cnt,
    output logic [31:0]       mispred_cnt
`endif
);

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam int         PW         = $clog2(QDEPTH);
    localparam int         EW         = PHTIDX + 1;   // {idx, taken}

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAIN,
        S_STALL
    } state_e;

    // gshare hash: word-aligned PC bits XOR left-zero-extended history.
    function automatic logic [PHTIDX-1:0] gshare_idx(
        input logic [PHTIDX-1:0] pc_bits,
        input logic [GHRLEN-1:0] ghr
    );
        return pc_bits ^ PHTIDX'(ghr);
    endfunction

    // -------------------------------------------------------------------------
    // Declarations
    // -------------------------------------------------------------------------
    logic [GHRLEN-1:0] ghr_q, ghr_d;

    logic [EW-1:0]     mem_q [QDEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [PW:0]       count_q, count_d;
    logic [EW-1:0]     head;

    state_e            state_q, state_d;

    logic [PHTIDX-1:0] pht_w_idx_q;
    logic              br_en_q;
    logic              update_pht_q;
    logic              mis_predict_q;

    logic              fetch_branch;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              mispred;
    logic [PHTIDX-1:0] resolve_idx;

    // PC bits outside the hash window are intentionally ignored.
    logic              unused_pc_bits;
    assign unused_pc_bits = ^{fetch_pc[31:PHTIDX+2], fetch_pc[1:0],
                              resolve_pc[31:PHTIDX+2], resolve_pc[1:0]};

    // -------------------------------------------------------------------------
    // Fetch side: lookup index, qualified prediction, history snapshot
    // -------------------------------------------------------------------------
    assign fetch_branch = fetch_valid && (fetch_opcode == OPC_BRANCH);
    assign pht_r_idx    = gshare_idx(fetch_pc[PHTIDX+1:2], ghr_q);
    assign pred_taken   = fetch_branch && pred_result;
    assign fetch_ghr    = ghr_q;

    // -------------------------------------------------------------------------
    // Resolve side: handshake and mispredict detection
    // -------------------------------------------------------------------------
    assign full          = (count_q == (PW+1)'(QDEPTH));
    assign empty         = (count_q == '0);
    // No write bypass when full: a same-cycle pop does not free a slot.
    assign resolve_ready = !full;
    assign push          = resolve_valid && !full;
    assign mispred       = push && (resolve_taken != resolve_pred);
    assign resolve_idx   = gshare_idx(resolve_pc[PHTIDX+1:2], resolve_ghr);

    // GHR next state: repair beats the speculative shift, since a fetch in
    // the same cycle as the repair is on the wrong path.
    always_comb begin
        // NOTE: every always_comb target gets a default first so that no
        // path leaves it unassigned; otherwise a latch is inferred.
        ghr_d = ghr_q;
        if (mispred) begin
            ghr_d = {resolve_ghr[GHRLEN-2:0], resolve_taken};
        end else if (fetch_branch) begin
            ghr_d = {ghr_q[GHRLEN-2:0], pred_result};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so that every
        // flop samples pre-edge values regardless of statement order.
        if (rst) ghr_q <= '0;
        else     ghr_q <= ghr_d;
    end

    // -------------------------------------------------------------------------
    // Update FIFO
    // -------------------------------------------------------------------------
    assign head = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;   // idle, or push+pop cancels out
        endcase
    end

    // NOTE: the storage array is not reset. Only the pointers and the count
    // decide which entries are live, so resetting the data would only cost
    // reset fan-out.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {resolve_idx, resolve_taken};
    end

    // Pointers are PW bits wide, so they wrap modulo QDEPTH on their own.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // -------------------------------------------------------------------------
    // Drain FSM
    //   IDLE  : nothing queued. A push moves to DRAIN on the same edge, so the
    //           entry is popped the next cycle (never in its push cycle).
    //   DRAIN : pops the head each cycle unless upd_stall is high.
    //   STALL : head held until upd_stall drops.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (push || !empty) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (empty) begin
                    state_d = push ? S_DRAIN : S_IDLE;
                end else if (upd_stall) begin
                    state_d = S_STALL;
                end else begin
                    pop = 1'b1;
                    // The last entry leaves with no refill arriving.
                    if ((count_q == (PW+1)'(1)) && !push) state_d = S_IDLE;
                end
            end
            S_STALL: begin
                if (!upd_stall) state_d = S_DRAIN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // -------------------------------------------------------------------------
    // Registered PHT write request and mispredict pulse
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pht_w_idx_q   <= '0;
            br_en_q       <= 1'b0;
            update_pht_q  <= 1'b0;
            mis_predict_q <= 1'b0;
        end else begin
            update_pht_q  <= pop;
            mis_predict_q <= mispred;
            if (pop) begin
                pht_w_idx_q <= head[EW-1:1];
                br_en_q     <= head[0];
            end
        end
    end

    assign pht_w_idx   = pht_w_idx_q;
    assign br_en       = br_en_q;
    assign update_pht  = update_pht_q;
    assign mis_predict = mis_predict_q;

`ifdef BP_STATS_EN
    // -------------------------------------------------------------------------
    // Statistics: both counters advance on the edge that registers the event
    // and wrap naturally at 2**32.
    // -------------------------------------------------------------------------
    logic [31:0] br_cnt_q;
    logic [31:0] mispred_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_cnt_q      <= '0;
            mispred_cnt_q <= '0;
        end else begin
            if (push)    br_cnt_q      <= br_cnt_q + 32'd1;
            if (mispred) mispred_cnt_q <= mispred_cnt_q + 32'd1;
        end
    end

    assign br_cnt      = br_cnt_q;
    assign mispred_cnt = mispred_cnt_q;
`endif

endmodule
